// File: rtl/matmul_arbiter.sv
// Round-robin arbiter that shares one matrix multiplier between NUM_REQ
// requesters, launches jobs with a start pulse, watches mm_busy for
// completion (with start/run watchdogs) and offsets the multiplier's local
// addresses by the granted requester's base addresses.
module matmul_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 4,
  parameter int RUN_TIMEOUT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] x_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] y_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] z_base,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          active,
  output logic                          mm_start,
  input  logic                          mm_busy,
  input  logic [ADDR_WIDTH-1:0]         mm_x_addr,
  input  logic [ADDR_WIDTH-1:0]         mm_y_addr,
  input  logic [ADDR_WIDTH-1:0]         mm_z_addr,
  output logic [ADDR_WIDTH-1:0]         x_addr,
  output logic [ADDR_WIDTH-1:0]         y_addr,
  output logic [ADDR_WIDTH-1:0]         z_addr
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_MAX = (START_TIMEOUT > RUN_TIMEOUT) ? START_TIMEOUT : RUN_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX + 2);

  localparam logic [WD_W-1:0]  START_LIM = WD_W'(START_TIMEOUT);
  localparam logic [WD_W-1:0]  RUN_LIM   = WD_W'(RUN_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    FINISH
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       idx;
  logic [WD_W-1:0]        wd;
  logic [WD_W-1:0]        wd_inc;
  logic [ADDR_WIDTH-1:0]  x_lat;
  logic [ADDR_WIDTH-1:0]  y_lat;
  logic [ADDR_WIDTH-1:0]  z_lat;
  logic                   found;
  logic [IDX_W-1:0]       sel_idx;
  logic [ADDR_WIDTH-1:0]  sel_x;
  logic [ADDR_WIDTH-1:0]  sel_y;
  logic [ADDR_WIDTH-1:0]  sel_z;

  // Saturating watchdog increment so a long stall never wraps back to zero.
  assign wd_inc = (wd == '1) ? wd : wd + 1'b1;

  // Round-robin pick: first requester at or above the pointer, else wrap to the lowest below it.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IDX_W'(j) >= ptr)) begin
        found   = 1'b1;
        sel_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IDX_W'(j) < ptr)) begin
        found   = 1'b1;
        sel_idx = IDX_W'(j);
      end
    end
  end

  // Select the winning requester's base-address slices for latching.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel_idx == IDX_W'(j)) begin
        sel_x = x_base[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_y = y_base[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_z = z_base[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Job sequencer; every handshake output is a register so it is glitch-free.
  // err is loaded on the way into FINISH and so doubles as the job's error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      wd       <= '0;
      x_lat    <= '0;
      y_lat    <= '0;
      z_lat    <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      active   <= 1'b0;
      mm_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx      <= sel_idx;
            x_lat    <= sel_x;
            y_lat    <= sel_y;
            z_lat    <= sel_z;
            grant    <= ONE_HOT0 << sel_idx;
            mm_start <= 1'b1;
            active   <= 1'b1;
            wd       <= '0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          mm_start <= 1'b0;
          wd       <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (mm_busy) begin
            wd    <= '0;
            state <= RUN;
          end else begin
            wd <= wd_inc;
            if (wd_inc == START_LIM) begin
              done  <= grant;
              grant <= '0;
              err   <= 1'b1;
              state <= FINISH;
            end
          end
        end
        RUN: begin
          if (!mm_busy) begin
            done  <= grant;
            grant <= '0;
            err   <= 1'b0;
            state <= FINISH;
          end else begin
            wd <= wd_inc;
            if ((RUN_TIMEOUT != 0) && (wd_inc == RUN_LIM)) begin
              done  <= grant;
              grant <= '0;
              err   <= 1'b1;
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done   <= '0;
          err    <= 1'b0;
          active <= 1'b0;
          ptr    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign x_addr = mm_x_addr + x_lat;
  assign y_addr = mm_y_addr + y_lat;
  assign z_addr = mm_z_addr + z_lat;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter with two requesters, START_TIMEOUT=4
// and RUN_TIMEOUT=50. The multiplier is modelled by driving mm_busy and the
// local addresses directly from the stimulus sequence.
module tb_matmul_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] x_base;
  logic [63:0] y_base;
  logic [63:0] z_base;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        err;
  logic        active;
  logic        mm_start;
  logic        mm_busy;
  logic [31:0] mm_x_addr;
  logic [31:0] mm_y_addr;
  logic [31:0] mm_z_addr;
  logic [31:0] x_addr;
  logic [31:0] y_addr;
  logic [31:0] z_addr;

  logic [31:0] xb [2];
  logic [31:0] yb [2];
  logic [31:0] zb [2];

  int checkCount = 0;
  int passCount  = 0;

  assign x_base = {xb[1], xb[0]};
  assign y_base = {yb[1], yb[0]};
  assign z_base = {zb[1], zb[0]};

  matmul_arbiter #(
    .ADDR_WIDTH   (32),
    .NUM_REQ      (2),
    .START_TIMEOUT(4),
    .RUN_TIMEOUT  (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .x_base   (x_base),
    .y_base   (y_base),
    .z_base   (z_base),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .active   (active),
    .mm_start (mm_start),
    .mm_busy  (mm_busy),
    .mm_x_addr(mm_x_addr),
    .mm_y_addr(mm_y_addr),
    .mm_z_addr(mm_z_addr),
    .x_addr   (x_addr),
    .y_addr   (y_addr),
    .z_addr   (z_addr)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] reqV, input logic busyV);
    req     = reqV;
    mm_busy = busyV;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One complete job: launch, busyLen cycles of mm_busy, completion, back to IDLE.
  task automatic doJob(input logic [1:0] reqV, input logic [1:0] expGrant,
                       input int busyLen, input bit holdReq);
    int          ei;
    logic [31:0] expX;
    logic [31:0] expY;
    logic [31:0] expZ;
    ei   = expGrant[1] ? 1 : 0;
    expX = xb[ei] + mm_x_addr;
    expY = yb[ei] + mm_y_addr;
    expZ = zb[ei] + mm_z_addr;
    applyStimulus(reqV, 1'b0);
    tick();
    checkOutput("launch_start", mm_start, 1);
    checkOutput("launch_grant", grant, expGrant);
    checkOutput("launch_active", active, 1);
    checkOutput("x_addr", x_addr, expX);
    checkOutput("y_addr", y_addr, expY);
    checkOutput("z_addr", z_addr, expZ);
    applyStimulus(reqV, 1'b1);
    for (int k = 0; k < busyLen; k++) begin
      tick();
      checkOutput("run_start_low", mm_start, 0);
      checkOutput("run_grant", grant, expGrant);
      checkOutput("run_no_done", done, 0);
    end
    applyStimulus(reqV, 1'b0);
    tick();
    checkOutput("done_pulse", done, expGrant);
    checkOutput("done_err", err, 0);
    checkOutput("done_grant_low", grant, 0);
    if (!holdReq) applyStimulus(2'b00, 1'b0);
    tick();
    checkOutput("done_clear", done, 0);
    checkOutput("idle_active", active, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 2'b00;
    mm_busy   = 1'b0;
    mm_x_addr = 32'h24;
    mm_y_addr = 32'h10;
    mm_z_addr = 32'h8;
    xb[0] = 32'h100;  yb[0] = 32'h200;  zb[0] = 32'h300;
    xb[1] = 32'h1000; yb[1] = 32'h2000; zb[1] = 32'h3000;

    tick();
    tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_start", mm_start, 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_active_noreq", active, 0);

    // Single job for requester 0 with a 20-cycle busy window.
    doJob(2'b01, 2'b01, 20, 1'b0);

    // Requester 1 alone; pointer then returns to 0.
    doJob(2'b10, 2'b10, 5, 1'b0);

    // Both requesting continuously: requester 0 first, then strict alternation.
    doJob(2'b11, 2'b01, 3, 1'b1);
    doJob(2'b11, 2'b10, 3, 1'b1);
    doJob(2'b11, 2'b01, 3, 1'b1);
    doJob(2'b11, 2'b10, 3, 1'b0);

    // Start timeout: mm_busy never rises.
    applyStimulus(2'b01, 1'b0);
    tick();
    checkOutput("st_launch", mm_start, 1);
    repeat (4) tick();
    checkOutput("st_no_done_yet", done, 0);
    tick();
    checkOutput("st_done", done, 2'b01);
    checkOutput("st_err", err, 1);
    checkOutput("st_grant_low", grant, 0);
    applyStimulus(2'b00, 1'b0);
    tick();
    checkOutput("st_idle", active, 0);
    checkOutput("st_err_clear", err, 0);
    doJob(2'b10, 2'b10, 4, 1'b0);

    // Run timeout: mm_busy stuck high, done/err 50 cycles after entering RUN.
    applyStimulus(2'b01, 1'b0);
    tick();
    checkOutput("rt_grant", grant, 2'b01);
    applyStimulus(2'b01, 1'b1);
    tick();
    tick();
    repeat (49) tick();
    checkOutput("rt_no_done_yet", done, 0);
    checkOutput("rt_active", active, 1);
    tick();
    checkOutput("rt_done", done, 2'b01);
    checkOutput("rt_err", err, 1);
    applyStimulus(2'b00, 1'b0);
    tick();
    checkOutput("rt_idle", active, 0);

    // Reset in the middle of requester 1's job while the pointer sits at 1.
    applyStimulus(2'b10, 1'b0);
    tick();
    checkOutput("mr_grant", grant, 2'b10);
    applyStimulus(2'b10, 1'b1);
    repeat (4) tick();
    checkOutput("mr_active", active, 1);
    rst = 1'b1;
    #1;
    checkOutput("mr_grant_drop", grant, 0);
    checkOutput("mr_active_drop", active, 0);
    checkOutput("mr_start_drop", mm_start, 0);
    checkOutput("mr_no_done", done, 0);
    tick();
    checkOutput("mr_no_done_held", done, 0);
    applyStimulus(2'b11, 1'b0);
    rst       = 1'b0;
    xb[0]     = 32'hFFFF_FFFF;
    mm_x_addr = 32'h2;

    // Pointer was cleared by reset, so requester 0 wins; its base wraps.
    doJob(2'b11, 2'b01, 3, 1'b0);
    checkOutput("wrap_x_addr", x_addr, 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
